// File: rtl/reg_file_wb.sv
// Write-back register file fed by Reg_mux_out.
// NUM_REGS x DATA_W registers, one synchronous write port, two registered
// read ports with write-to-read bypass, and a per-register busy scoreboard
// that flags operand hazards to the issue logic.
// Optional build macro: REG_ZERO_HARDWIRE_EN makes register 0 a constant
// zero (writes dropped, never marked busy).
module reg_file_wb #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 16   // must equal 2**ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              W_en,
    input  logic [ADDR_W-1:0] W_addr,
    input  logic [DATA_W-1:0] W_data,
    input  logic              R_en,
    input  logic [ADDR_W-1:0] R_addr_a,
    input  logic [ADDR_W-1:0] R_addr_b,
    output logic [DATA_W-1:0] R_data_a,
    output logic [DATA_W-1:0] R_data_b,
    input  logic              Iss_en,
    input  logic [ADDR_W-1:0] Iss_addr,
    output logic              Busy_a,
    output logic              Busy_b,
    output logic              Hazard
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;
    logic                wr_fire;
    logic [DATA_W-1:0]   rd_next_a;
    logic [DATA_W-1:0]   rd_next_b;

    // Qualify the write strobe; with a hardwired zero register, writes to 0 vanish.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        wr_fire = W_en;
`ifdef REG_ZERO_HARDWIRE_EN
        if (W_addr == '0) wr_fire = 1'b0;
`else
`endif
    end

    // Next read data per port: array value, or the same-cycle write data on an address match.
    always_comb begin
        rd_next_a = regs[R_addr_a];
        rd_next_b = regs[R_addr_b];
        if (wr_fire && (R_addr_a == W_addr)) rd_next_a = W_data;
        if (wr_fire && (R_addr_b == W_addr)) rd_next_b = W_data;
    end

    // Scoreboard update: clear on write-back first, then set on issue so a collision ends set.
    always_comb begin
        busy_next = busy;
        if (W_en)   busy_next[W_addr]   = 1'b0;
        if (Iss_en) busy_next[Iss_addr] = 1'b1;
`ifdef REG_ZERO_HARDWIRE_EN
        busy_next[0] = 1'b0;
`else
`endif
    end

    // Register array write port with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the array is cleared on reset because the architecture promises all-zero registers; this costs a reset net per flop, so it is not a RAM macro.
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_fire) begin
            // NOTE: sequential state uses non-blocking assignment so all flops sample pre-edge values.
            regs[W_addr] <= W_data;
        end
    end

    // Registered read ports; hold their value while R_en is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            R_data_a <= '0;
            R_data_b <= '0;
        end else if (R_en) begin
            R_data_a <= rd_next_a;
            R_data_b <= rd_next_b;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (reset) busy <= '0;
        else       busy <= busy_next;
    end

    // Hazard flags read the registered scoreboard only; no same-cycle forwarding.
    assign Busy_a = busy[R_addr_a];
    assign Busy_b = busy[R_addr_b];
    assign Hazard = (Busy_a | Busy_b) & R_en;

endmodule

// File: tb/tb_reg_file_wb.sv
// Self-checking bench for reg_file_wb: directed vector table, hand-written
// register-0 sequence, then randomized traffic against a behavioural model.
module tb_reg_file_wb;

    logic        clk;
    logic        reset;
    logic        w_en;
    logic [3:0]  w_addr;
    logic [63:0] w_data;
    logic        r_en;
    logic [3:0]  r_addr_a;
    logic [3:0]  r_addr_b;
    logic [63:0] r_data_a;
    logic [63:0] r_data_b;
    logic        iss_en;
    logic [3:0]  iss_addr;
    logic        busy_a;
    logic        busy_b;
    logic        hazard;

    int checks   = 0;
    int failures = 0;

    reg_file_wb #(.DATA_W(64), .ADDR_W(4), .NUM_REGS(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .W_en     (w_en),
        .W_addr   (w_addr),
        .W_data   (w_data),
        .R_en     (r_en),
        .R_addr_a (r_addr_a),
        .R_addr_b (r_addr_b),
        .R_data_a (r_data_a),
        .R_data_b (r_data_b),
        .Iss_en   (iss_en),
        .Iss_addr (iss_addr),
        .Busy_a   (busy_a),
        .Busy_b   (busy_b),
        .Hazard   (hazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        we;
        logic [3:0]  wa;
        logic [63:0] wd;
        logic        re;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic        ie;
        logic [3:0]  ia;
        logic [63:0] ea;
        logic [63:0] eb;
        logic        eba;
        logic        ebb;
        logic        eh;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    // Behavioural reference state
    logic [63:0] m_regs [16];
    logic        m_busy [16];
    logic [63:0] m_a;
    logic [63:0] m_b;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rst, input logic we, input logic [3:0] wa, input logic [63:0] wd,
                         input logic re, input logic [3:0] ra, input logic [3:0] rb,
                         input logic ie, input logic [3:0] ia);
        reset = rst; w_en = we; w_addr = wa; w_data = wd;
        r_en = re; r_addr_a = ra; r_addr_b = rb; iss_en = ie; iss_addr = ia;
    endtask

    // Apply the architectural rules for one clock edge using the current inputs.
    task automatic model_step();
        logic we_eff;
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                m_regs[i] = 64'd0;
                m_busy[i] = 1'b0;
            end
            m_a = 64'd0;
            m_b = 64'd0;
        end else begin
            we_eff = w_en;
`ifdef REG_ZERO_HARDWIRE_EN
            if (w_addr == 4'd0) we_eff = 1'b0;
`else
`endif
            if (r_en) begin
                m_a = (we_eff && r_addr_a == w_addr) ? w_data : m_regs[r_addr_a];
                m_b = (we_eff && r_addr_b == w_addr) ? w_data : m_regs[r_addr_b];
            end
            if (we_eff) m_regs[w_addr] = w_data;
            if (w_en)   m_busy[w_addr] = 1'b0;
            if (iss_en) m_busy[iss_addr] = 1'b1;
`ifdef REG_ZERO_HARDWIRE_EN
            m_busy[0] = 1'b0;
`else
`endif
        end
    endtask

    logic [3:0] ra_r;
    logic [3:0] rb_r;

    initial begin
        drive(1'b1, 1'b0, 4'd0, 64'd0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0);

        //          rst   we    wa     wd                      re    ra     rb     ie    ia     ea                      eb                      eba   ebb   eh
        vecs[0]  = '{1'b1, 1'b0, 4'd0,  64'h0,                 1'b1, 4'd3,  4'd15, 1'b0, 4'd0,  64'h0,                  64'h0,                  1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 4'd5,  64'hDEADBEEF_01234567, 1'b0, 4'd3,  4'd15, 1'b0, 4'd0,  64'h0,                  64'h0,                  1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 4'd0,  64'h0,                 1'b1, 4'd5,  4'd15, 1'b0, 4'd0,  64'hDEADBEEF_01234567,  64'h0,                  1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 4'd0,  64'h0,                 1'b0, 4'd5,  4'd5,  1'b0, 4'd0,  64'hDEADBEEF_01234567,  64'h0,                  1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 4'd7,  64'hA5A5A5A5_A5A5A5A5, 1'b1, 4'd7,  4'd7,  1'b0, 4'd0,  64'hA5A5A5A5_A5A5A5A5,  64'hA5A5A5A5_A5A5A5A5,  1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 4'd0,  64'h0,                 1'b0, 4'd9,  4'd7,  1'b1, 4'd9,  64'hA5A5A5A5_A5A5A5A5,  64'hA5A5A5A5_A5A5A5A5,  1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 4'd0,  64'h0,                 1'b1, 4'd9,  4'd7,  1'b0, 4'd0,  64'h0,                  64'hA5A5A5A5_A5A5A5A5,  1'b1, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 4'd9,  64'h99,                1'b1, 4'd9,  4'd9,  1'b0, 4'd0,  64'h99,                 64'h99,                 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 4'd0,  64'h0,                 1'b0, 4'd2,  4'd9,  1'b1, 4'd2,  64'h99,                 64'h99,                 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 4'd2,  64'h2222,              1'b0, 4'd2,  4'd2,  1'b1, 4'd2,  64'h99,                 64'h99,                 1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 4'd0,  64'h0,                 1'b1, 4'd2,  4'd9,  1'b0, 4'd0,  64'h2222,               64'h99,                 1'b1, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 4'd4,  64'h1,                 1'b0, 4'd4,  4'd2,  1'b1, 4'd4,  64'h2222,               64'h99,                 1'b1, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 4'd4,  64'h1234,              1'b1, 4'd4,  4'd2,  1'b1, 4'd4,  64'h0,                  64'h0,                  1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 4'd0,  64'h0,                 1'b1, 4'd4,  4'd5,  1'b0, 4'd0,  64'h0,                  64'h0,                  1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 4'd10, 64'hABCD,              1'b0, 4'd3,  4'd10, 1'b1, 4'd3,  64'h0,                  64'h0,                  1'b1, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 4'd0,  64'h0,                 1'b1, 4'd3,  4'd10, 1'b0, 4'd0,  64'h0,                  64'hABCD,               1'b1, 1'b0, 1'b1};
        vecs[16] = '{1'b0, 1'b1, 4'd3,  64'h3333,              1'b1, 4'd3,  4'd10, 1'b0, 4'd0,  64'h3333,               64'hABCD,               1'b0, 1'b0, 1'b0};

        tick();
        for (int v = 0; v < NVEC; v++) begin
            drive(vecs[v].rst, vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].re,
                  vecs[v].ra, vecs[v].rb, vecs[v].ie, vecs[v].ia);
            tick();
            check($sformatf("vec%0d r_data_a", v), r_data_a, vecs[v].ea);
            check($sformatf("vec%0d r_data_b", v), r_data_b, vecs[v].eb);
            check($sformatf("vec%0d busy_a", v), 64'(busy_a), 64'(vecs[v].eba));
            check($sformatf("vec%0d busy_b", v), 64'(busy_b), 64'(vecs[v].ebb));
            check($sformatf("vec%0d hazard", v), 64'(hazard), 64'(vecs[v].eh));
        end

        // Register 0: write with bypass, issue, then clear.
        drive(1'b0, 1'b1, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd0, 4'd0, 1'b0, 4'd0);
        tick();
`ifdef REG_ZERO_HARDWIRE_EN
        check("r0 bypass a", r_data_a, 64'h0);
        check("r0 bypass b", r_data_b, 64'h0);
`else
        check("r0 bypass a", r_data_a, 64'hFFFF_FFFF_FFFF_FFFF);
        check("r0 bypass b", r_data_b, 64'hFFFF_FFFF_FFFF_FFFF);
`endif
        drive(1'b0, 1'b0, 4'd0, 64'h0, 1'b1, 4'd0, 4'd0, 1'b1, 4'd0);
        tick();
`ifdef REG_ZERO_HARDWIRE_EN
        check("r0 read", r_data_a, 64'h0);
        check("r0 issue busy_a", 64'(busy_a), 64'd0);
        check("r0 issue hazard", 64'(hazard), 64'd0);
`else
        check("r0 read", r_data_a, 64'hFFFF_FFFF_FFFF_FFFF);
        check("r0 issue busy_a", 64'(busy_a), 64'd1);
        check("r0 issue hazard", 64'(hazard), 64'd1);
`endif
        drive(1'b0, 1'b1, 4'd0, 64'h5, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0);
        tick();
        check("r0 clear busy_a", 64'(busy_a), 64'd0);

        // Randomized traffic against the model, starting from a reset.
        drive(1'b1, 1'b0, 4'd0, 64'h0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0);
        model_step();
        tick();
        for (int n = 0; n < 1500; n++) begin
            reset    = ($urandom_range(0, 59) == 0);
            w_en     = 1'($urandom_range(0, 1));
            w_addr   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            w_data   = {$urandom, $urandom};
            r_en     = 1'($urandom_range(0, 1));
            r_addr_a = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            r_addr_b = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            iss_en   = 1'($urandom_range(0, 1));
            iss_addr = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            model_step();
            tick();
            ra_r = r_addr_a;
            rb_r = r_addr_b;
            check($sformatf("rnd%0d r_data_a", n), r_data_a, m_a);
            check($sformatf("rnd%0d r_data_b", n), r_data_b, m_b);
            check($sformatf("rnd%0d busy_a", n), 64'(busy_a), 64'(m_busy[ra_r]));
            check($sformatf("rnd%0d busy_b", n), 64'(busy_b), 64'(m_busy[rb_r]));
            check($sformatf("rnd%0d hazard", n), 64'(hazard), 64'((m_busy[ra_r] | m_busy[rb_r]) & r_en));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- Write-back register file that consumes the 64-bit output of the register-input select mux (Reg_mux_out).
- Holds NUM_REGS x DATA_W registers, with one synchronous write port and two registered read ports.
- Write-to-read bypass forwards a same-cycle write to a read of the same address.
- A per-register busy scoreboard is set when an instruction issues and cleared on write-back; it drives operand-hazard flags to the issue logic.

Parameters:
DATA_W, 64, register and port data width
ADDR_W, 4, register address width
NUM_REGS, 16, number of registers; must equal 2**ADDR_W

Ports:
clk  input  1  single system clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
W_en  input  1  write-back strobe
W_addr  input  ADDR_W  write-back destination register
W_data  input  DATA_W  write-back data, driven by Reg_mux_out
R_en  input  1  read strobe for both read ports
R_addr_a  input  ADDR_W  read port A address
R_addr_b  input  ADDR_W  read port B address
R_data_a  output  DATA_W  registered read data, port A
R_data_b  output  DATA_W  registered read data, port B
Iss_en  input  1  issue strobe: mark Iss_addr busy
Iss_addr  input  ADDR_W  destination register of issuing instruction
Busy_a  output  1  combinational: scoreboard bit for R_addr_a
Busy_b  output  1  combinational: scoreboard bit for R_addr_b
Hazard  output  1  combinational: (Busy_a | Busy_b) & R_en

Behaviour:
- Clocking/reset: one clock, clk. reset is synchronous, active-high.
- On a reset edge:
  - all registers clear to 0;
  - R_data_a/R_data_b clear to 0;
  - all scoreboard bits clear to 0, so Busy_a, Busy_b and Hazard read 0.
  - reset overrides W_en, R_en and Iss_en in the same cycle; a write or issue in flight is discarded.
- Write:
  - when W_en=1, regs[W_addr] <= W_data at the rising edge;
  - a write to a register that is not busy is legal and leaves the scoreboard unchanged.
- Read:
  - when R_en=1, R_data_x <= regs[R_addr_x] at the edge (latency 1 cycle);
  - when R_en=0, R_data_x holds its previous value.
- Bypass: when W_en=1, R_en=1 and R_addr_x == W_addr in the same cycle, R_data_x <= W_data (new data), never the stale value. The two ports are bypassed independently.
- Scoreboard, evaluated per edge:
  - Iss_en=1 sets busy[Iss_addr];
  - W_en=1 clears busy[W_addr];
  - simultaneous Iss_en and W_en to the same address: set wins and the bit ends at 1 (the new producer supersedes the old);
  - simultaneous Iss_en and W_en to different addresses: both take effect.
- Busy_a/Busy_b reflect the registered scoreboard only; there is no same-cycle forwarding of Iss_en or W_en into them.
- Address range: all addresses 0..NUM_REGS-1 are valid; there is no out-of-range case.
- Module is purely a slave; it never stalls writes, and Hazard is advisory to the issue logic.

Optional Feature:
- Macro: REG_ZERO_HARDWIRE_EN.
- Defined:
  - register 0 always reads 0, including via bypass;
  - writes to address 0 are discarded;
  - busy[0] is never set, so Busy_x=0 whenever R_addr_x=0;
  - Iss_en with Iss_addr=0 is a no-op.
- Undefined: register 0 is an ordinary register with identical rules to the others.

Test Plan:
- Reset then read: assert reset 1 cycle, R_en=1, R_addr_a=3, R_addr_b=15 -> R_data_a=R_data_b=0 next cycle; Busy_a=Busy_b=Hazard=0.
- Write then read: W_en, W_addr=5, W_data=64'hDEADBEEF_01234567; next cycle R_en, R_addr_a=5 -> R_data_a=64'hDEADBEEF_01234567 one cycle later; R_data_b holds when R_en=0.
- Bypass: same cycle W_en, W_addr=7, W_data=64'hA5A5A5A5_A5A5A5A5 with R_en, R_addr_a=7, R_addr_b=7 (old value 0) -> both ports = 64'hA5A5A5A5_A5A5A5A5 next cycle.
- Scoreboard:
  - Iss_en, Iss_addr=9 -> next cycle R_addr_a=9 gives Busy_a=1; with R_en=1, Hazard=1;
  - W_en, W_addr=9 -> Busy_a=0 the following cycle.
- Set/clear collision: busy[2]=1; same cycle Iss_en, Iss_addr=2 and W_en, W_addr=2 -> busy[2] stays 1 and regs[2]=W_data.
- Mid-operation reset: busy[4]=1, regs[4]=1; assert reset together with W_en, W_addr=4, W_data=64'h1234 -> afterwards regs[4]=0 and busy[4]=0.
- REG_ZERO_HARDWIRE_EN defined: W_en, W_addr=0, W_data=64'hFFFF_FFFF_FFFF_FFFF, then read address 0 -> 0. Also Iss_en, Iss_addr=0 -> Busy_a=0 with R_addr_a=0.
